store_write_buffer: RTL and testbench

Posted-store buffer between the pipeline's store port (memwrite/dataadr/writedata) and the data-memory write port.
- Accepts one word store per cycle from the MEM stage and queues it in a DEPTH-entry FIFO.
- Drains the queue to memory in program order over a valid/ready handshake.
- Raises stall to the hazard unit when full.
- Forwards pending store data to same-address loads so that loads never read stale memory.

---
 rtl/store_write_buffer_pkg.sv | 17 +
 rtl/store_fwd_match.sv | 38 +++
 rtl/store_write_buffer.sv | 97 +++++++++
 tb/tb_store_write_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared widths and entry layout for the posted-store write buffer.
// Entries hold a word address (byte offset dropped) plus one data word.
package store_write_buffer_pkg;

  localparam int STORE_ADDR_W    = 32;
  localparam int STORE_DATA_W    = 32;
  localparam int STORE_BUF_DEPTH = 4;
  localparam int STORE_WADDR_W   = STORE_ADDR_W - 2;

  typedef struct packed {
    logic [STORE_WADDR_W-1:0] word_addr;
    logic [STORE_DATA_W-1:0]  data;
  } store_entry_t;

  localparam int STORE_ENTRY_W = $bits(store_entry_t);

endpackage

// File: rtl/store_fwd_match.sv
// Age-ordered lookup of pending stores: combinational, youngest matching entry wins.
// Validity comes from rd_ptr/count, so only registered queue state is searched.
module store_fwd_match
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = STORE_BUF_DEPTH,
  parameter int WA_W   = STORE_WADDR_W,
  parameter int DATA_W = STORE_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic              rd_en,
  input  logic [WA_W-1:0]   rd_word_addr,
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [WA_W-1:0]   ent_addr [DEPTH],
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      if (rd_en && (CNT_W'(i) < count) && (ent_addr[slot] == rd_word_addr)) begin
        hit  = 1'b1;
        data = ent_data[slot];
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between MEM-stage stores and the memory write port, with load forwarding.
// Stores reach mem_* one cycle after acceptance; stall is raised while full, mem_* holds under !mem_ready.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = STORE_BUF_DEPTH,
  parameter int ADDR_W = STORE_ADDR_W,
  parameter int DATA_W = STORE_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     memwrite,
  input  logic [ADDR_W-1:0]        dataadr,
  input  logic [DATA_W-1:0]        writedata,
  output logic                     stall,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     mem_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]   ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              enq;
  logic              deq;

  // Byte-offset bits of word addresses carry no information here.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{dataadr[1:0], rd_addr[1:0]};

  // A full buffer rejects the store even if the head drains this cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign enq       = memwrite && !full;
  assign deq       = mem_valid && mem_ready;
  assign stall     = full;
  assign empty     = (count == '0);
  assign mem_valid = (count != '0);
  assign mem_addr  = {ent_addr[rd_ptr], 2'b00};
  assign mem_wdata = ent_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= dataadr[ADDR_W-1:2];
      ent_data[wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (memwrite && full) overflow <= 1'b1;
    end
  end

  store_fwd_match #(
    .DEPTH  (DEPTH),
    .WA_W   (WA_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fwd (
    .rd_en        (rd_en),
    .rd_word_addr (rd_addr[ADDR_W-1:2]),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .ent_addr     (ent_addr),
    .ent_data     (ent_data),
    .hit          (fwd_hit),
    .data         (fwd_data)
  );

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: a vector table of per-cycle inputs/expected
// outputs, then hand sequences for async reset mid-drain and full-plus-drain overflow.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        stall;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .stall     (stall),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic        rde;
    logic [31:0] radr;
    logic        st;
    logic        hit;
    logic [31:0] fd;
    logic        mv;
    logic [31:0] ma;
    logic [31:0] md;
    logic        emp;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Columns: mw, adr, wd, rdy, rde, radr | stall, hit, fwd_data, mem_valid, mem_addr, mem_wdata, empty, count, overflow
    // Expected outputs are those seen before the clock edge that consumes the inputs.
    vecs.push_back('{1, 240, 'h11, 1, 0, 0,     0, 0, 0,     0, 0, 0,       1, 0, 0}); // single store
    vecs.push_back('{0, 0, 0, 1, 0, 0,          0, 0, 0,     1, 240, 'h11,  0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 0, 0,       1, 0, 0});
    vecs.push_back('{1, 0, 'hA0, 0, 0, 0,       0, 0, 0,     0, 0, 0,       1, 0, 0}); // fill, backpressured
    vecs.push_back('{1, 4, 'hA1, 0, 0, 0,       0, 0, 0,     1, 0, 'hA0,    0, 1, 0});
    vecs.push_back('{1, 8, 'hA2, 0, 0, 0,       0, 0, 0,     1, 0, 'hA0,    0, 2, 0});
    vecs.push_back('{1, 12, 'hA3, 0, 0, 0,      0, 0, 0,     1, 0, 'hA0,    0, 3, 0});
    vecs.push_back('{1, 16, 'hA4, 0, 0, 0,      1, 0, 0,     1, 0, 'hA0,    0, 4, 0}); // 5th store dropped
    vecs.push_back('{0, 0, 0, 0, 1, 8,          1, 1, 'hA2,  1, 0, 'hA0,    0, 4, 1});
    vecs.push_back('{0, 0, 0, 1, 1, 16,         1, 0, 0,     1, 0, 'hA0,    0, 4, 1}); // dropped store invisible
    vecs.push_back('{0, 0, 0, 0, 0, 0,          0, 0, 0,     1, 4, 'hA1,    0, 3, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0,          0, 0, 0,     1, 4, 'hA1,    0, 3, 1}); // held stable
    vecs.push_back('{0, 0, 0, 1, 0, 0,          0, 0, 0,     1, 4, 'hA1,    0, 3, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 0,          0, 0, 0,     1, 8, 'hA2,    0, 2, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 0,          0, 0, 0,     1, 12, 'hA3,   0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 0, 0,       1, 0, 1});
    vecs.push_back('{1, 240, 'h11, 0, 0, 0,     0, 0, 0,     0, 0, 0,       1, 0, 1}); // forwarding
    vecs.push_back('{1, 240, 'h22, 0, 1, 240,   0, 1, 'h11,  1, 240, 'h11,  0, 1, 1}); // same-cycle store not seen
    vecs.push_back('{0, 0, 0, 0, 1, 240,        0, 1, 'h22,  1, 240, 'h11,  0, 2, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 242,        0, 1, 'h22,  1, 240, 'h11,  0, 2, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 244,        0, 0, 0,     1, 240, 'h11,  0, 2, 1});
    vecs.push_back('{0, 0, 0, 1, 1, 240,        0, 1, 'h22,  1, 240, 'h11,  0, 2, 1});
    vecs.push_back('{1, 'h100, 'hB0, 0, 1, 240, 0, 1, 'h22,  1, 240, 'h22,  0, 1, 1});
    vecs.push_back('{1, 'h104, 'hB1, 1, 0, 0,   0, 0, 0,     1, 240, 'h22,  0, 2, 1}); // enq+deq at count 2
    vecs.push_back('{1, 'h108, 'hB2, 1, 0, 0,   0, 0, 0,     1, 'h100, 'hB0, 0, 2, 1});
    vecs.push_back('{1, 'h10C, 'hB3, 1, 0, 0,   0, 0, 0,     1, 'h104, 'hB1, 0, 2, 1});
    vecs.push_back('{0, 0, 0, 1, 1, 'h10C,      0, 1, 'hB3,  1, 'h108, 'hB2, 0, 2, 1});
    vecs.push_back('{1, 'h200, 'hC0, 0, 0, 0,   0, 0, 0,     1, 'h10C, 'hB3, 0, 1, 1});
    vecs.push_back('{1, 'h204, 'hC1, 0, 0, 0,   0, 0, 0,     1, 'h10C, 'hB3, 0, 2, 1});
    vecs.push_back('{1, 'h208, 'hC2, 0, 0, 0,   0, 0, 0,     1, 'h10C, 'hB3, 0, 3, 1});
    vecs.push_back('{1, 'h20C, 'hC3, 1, 0, 0,   1, 0, 0,     1, 'h10C, 'hB3, 0, 4, 1}); // full + drain
    vecs.push_back('{0, 0, 0, 0, 1, 'h20C,      0, 0, 0,     1, 'h200, 'hC0, 0, 3, 1});

    rst_n = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    mem_ready = 1'b0; rd_en = 1'b1; rd_addr = '0;
    #12;
    chk("rst mem_valid", mem_valid, 0);
    chk("rst empty", empty, 1);
    chk("rst stall", stall, 0);
    chk("rst count", count, 0);
    chk("rst fwd_hit", fwd_hit, 0);
    chk("rst fwd_data", fwd_data, 0);
    chk("rst overflow", overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      memwrite = vecs[i].mw; dataadr = vecs[i].adr; writedata = vecs[i].wd;
      mem_ready = vecs[i].rdy; rd_en = vecs[i].rde; rd_addr = vecs[i].radr;
      #1;
      chk($sformatf("v%0d stall", i), stall, vecs[i].st);
      chk($sformatf("v%0d fwd_hit", i), fwd_hit, vecs[i].hit);
      chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].fd);
      chk($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].mv);
      if (vecs[i].mv) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ma);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].md);
      end
      chk($sformatf("v%0d empty", i), empty, vecs[i].emp);
      chk($sformatf("v%0d count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d overflow", i), overflow, vecs[i].ovf);
      @(posedge clk); #1;
    end

    // Reset mid-drain with three entries pending and memory stalled.
    memwrite = 1'b0; mem_ready = 1'b0; rd_en = 1'b1; rd_addr = 32'h200;
    #1;
    chk("pre_rst count", count, 3);
    chk("pre_rst fwd_hit", fwd_hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst mem_valid", mem_valid, 0);
    chk("mid_rst count", count, 0);
    chk("mid_rst empty", empty, 1);
    chk("mid_rst stall", stall, 0);
    chk("mid_rst overflow", overflow, 0);
    chk("mid_rst fwd_hit", fwd_hit, 0);
    chk("mid_rst fwd_data", fwd_data, 0);
    @(posedge clk);
    @(negedge clk) begin rst_n = 1'b1; mem_ready = 1'b1; rd_en = 1'b0; end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d mem_valid", k), mem_valid, 0);
    end

    // Fresh fill, then a store at full while the head drains.
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      memwrite = 1'b1;
      dataadr = (k == 0) ? 32'h302 : 32'h300 + 32'(4 * k);
      writedata = 32'hD0 + 32'(k);
      @(posedge clk); #1;
    end
    memwrite = 1'b0;
    #1;
    chk("fill count", count, 4);
    chk("fill stall", stall, 1);
    chk("fill overflow", overflow, 0);
    chk("fill mem_addr", mem_addr, 32'h300);
    chk("fill mem_wdata", mem_wdata, 32'hD0);
    memwrite = 1'b1; dataadr = 32'h310; writedata = 32'hE0; mem_ready = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0; mem_ready = 1'b0;
    #1;
    chk("fulldrain count", count, 3);
    chk("fulldrain overflow", overflow, 1);
    chk("fulldrain stall", stall, 0);
    mem_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk($sformatf("drain%0d mem_addr", k), mem_addr, 32'h300 + 32'(4 * k));
      chk($sformatf("drain%0d mem_wdata", k), mem_wdata, 32'hD0 + 32'(k));
      @(posedge clk); #1;
    end
    #1;
    chk("drain empty", empty, 1);
    chk("drain count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
